// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - multiplexed 7-segment scan driver with frame-synchronous double buffering
// Purpose : scans DIGITS multiplexed digits, SCAN_DIV clocks per digit. New patterns are
//           captured into shadow registers on load and copied to the displayed set only at
//           a frame boundary, so a frame never shows a mix of old and new data.
// Ports   : clk, reset (async, active-high)
//           data_in[DIGITS*SEG_WIDTH] / enable_in[DIGITS] / blink_in[DIGITS] - captured on load
//           load        - single-cycle capture strobe
//           seg_out     - registered segment drive, active-low
//           digit_sel   - registered digit select, active-low one-hot
//           pending     - shadow holds data not yet committed
//           frame_done  - high on the cycle of each frame boundary
// Option  : DISPLAY_SCAN_BLINK_EN adds per-digit blinking (blink_in, frame counter, blink phase).
module display_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int SEG_WIDTH    = 7,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIGITS*SEG_WIDTH-1:0] data_in,
  input  logic [DIGITS-1:0]           enable_in,
  input  logic [DIGITS-1:0]           blink_in,
  input  logic                        load,
  output logic [SEG_WIDTH-1:0]        seg_out,
  output logic [DIGITS-1:0]           digit_sel,
  output logic                        pending,
  output logic                        frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]                 presc;
  logic [IW-1:0]                 idx;
  logic                          tick;
  logic                          boundary;
  logic [DIGITS*SEG_WIDTH-1:0]   shd_data;
  logic [DIGITS*SEG_WIDTH-1:0]   act_data;
  logic [DIGITS-1:0]             shd_en;
  logic [DIGITS-1:0]             act_en;
  logic                          blink_blank;
  logic                          blank;
  logic [SEG_WIDTH-1:0]          cur_seg;

  assign tick       = (presc == PRESC_LAST);
  assign boundary   = tick && (idx == IDX_LAST);
  assign frame_done = boundary;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        if (idx == IDX_LAST) idx <= '0;
        else                 idx <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // A load on the boundary cycle goes straight to the active set (and beats any
  // older pending shadow); otherwise loads only touch the shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_data <= '0;
      shd_en   <= '0;
      act_data <= '0;
      act_en   <= '0;
      pending  <= 1'b0;
    end else if (boundary) begin
      pending <= 1'b0;
      if (load) begin
        act_data <= data_in;
        act_en   <= enable_in;
      end else if (pending) begin
        act_data <= shd_data;
        act_en   <= shd_en;
      end
    end else if (load) begin
      shd_data <= data_in;
      shd_en   <= enable_in;
      pending  <= 1'b1;
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]     frame_cnt;
  logic              blink_phase;
  logic [DIGITS-1:0] shd_blink;
  logic [DIGITS-1:0] act_blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Blink bits follow exactly the same shadow/commit path as the patterns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shd_blink <= '0;
      act_blink <= '0;
    end else if (boundary) begin
      if (load)         act_blink <= blink_in;
      else if (pending) act_blink <= shd_blink;
    end else if (load) begin
      shd_blink <= blink_in;
    end
  end

  assign blink_blank = blink_phase & act_blink[idx];
`else
  logic unused_blink_in;
  assign unused_blink_in = ^blink_in;
  assign blink_blank     = 1'b0;
`endif

  assign cur_seg = act_data[int'(idx)*SEG_WIDTH +: SEG_WIDTH];
  assign blank   = ~act_en[idx] | blink_blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out   <= '1;
      digit_sel <= '1;
    end else begin
      seg_out   <= blank ? '1 : ~cur_seg;
      digit_sel <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - scoreboard bench for display_scan_driver
module tb_display_scan_driver;

  localparam int DIGITS       = 4;
  localparam int SEG_WIDTH    = 7;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [DIGITS*SEG_WIDTH-1:0] data_in;
  logic [DIGITS-1:0]           enable_in;
  logic [DIGITS-1:0]           blink_in;
  logic                        load;
  logic [SEG_WIDTH-1:0]        seg_out;
  logic [DIGITS-1:0]           digit_sel;
  logic                        pending;
  logic                        frame_done;

  always #5 clk = ~clk;

  display_scan_driver #(
    .DIGITS(DIGITS), .SEG_WIDTH(SEG_WIDTH), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .enable_in(enable_in),
    .blink_in(blink_in), .load(load), .seg_out(seg_out), .digit_sel(digit_sel),
    .pending(pending), .frame_done(frame_done)
  );

  typedef struct {
    int                          cyc;
    logic [DIGITS*SEG_WIDTH-1:0] data;
    logic [DIGITS-1:0]           en;
    logic [DIGITS-1:0]           blink;
  } load_t;

  typedef struct {
    int                   cyc;
    logic [SEG_WIDTH-1:0] seg;
    logic [DIGITS-1:0]    sel;
    logic                 pend;
    logic                 fd;
  } exp_t;

  load_t loads[$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 0;

  // Expected outputs after clock edge c (edge 0 = first edge after reset release).
  // Frame f shows the newest load made before f's first edge; blink phase flips
  // every BLINK_FRAMES frames.
  function automatic exp_t model(int c);
    exp_t                        e;
    int                          d, f, last_load;
    logic [DIGITS*SEG_WIDTH-1:0] pat;
    logic [DIGITS-1:0]           en, bl;
    logic [SEG_WIDTH-1:0]        seg7;
    bit                          phase;
    pat = '0; en = '0; bl = '0;
    d = (c / SCAN_DIV) % DIGITS;
    f = c / FRAME;
    last_load = -1;
    foreach (loads[i]) begin
      if (loads[i].cyc < f * FRAME) begin
        pat = loads[i].data; en = loads[i].en; bl = loads[i].blink;
      end
      if (loads[i].cyc <= c) last_load = loads[i].cyc;
    end
`ifdef DISPLAY_SCAN_BLINK_EN
    phase = ((f / BLINK_FRAMES) % 2) == 1;
`else
    phase = 1'b0;
`endif
    seg7   = pat[d*SEG_WIDTH +: SEG_WIDTH];
    e.cyc  = c;
    e.seg  = (en[d] && !(bl[d] && phase)) ? ~seg7 : '1;
    e.sel  = ~(DIGITS'(1) << d);
    e.pend = (last_load >= 0) && (last_load / FRAME == c / FRAME) && (c % FRAME != FRAME - 1);
    e.fd   = ((c + 1) % FRAME) == FRAME - 1;
    return e;
  endfunction

  task automatic check(string name, int c, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_empty got=0 want=1 entries");
      end else begin
        e = exp_q.pop_front();
        check("seg_out",    e.cyc, 32'(seg_out),    32'(e.seg));
        check("digit_sel",  e.cyc, 32'(digit_sel),  32'(e.sel));
        check("pending",    e.cyc, 32'(pending),    32'(e.pend));
        check("frame_done", e.cyc, 32'(frame_done), 32'(e.fd));
      end
    end
  end

  task automatic drive_cycle(int c, bit ld, logic [DIGITS*SEG_WIDTH-1:0] d,
                             logic [DIGITS-1:0] en, logic [DIGITS-1:0] bl);
    load_t l;
    load = ld; data_in = d; enable_in = en; blink_in = bl;
    if (ld) begin
      l.cyc = c; l.data = d; l.en = en; l.blink = bl;
      loads.push_back(l);
    end
    exp_q.push_back(model(c));
    mon_en = 1;
    @(posedge clk);
    #2;
  endtask

  // Directed loads in the first frames, random traffic afterwards.
  task automatic run_phase(int ncyc);
    bit                          ld;
    logic [DIGITS*SEG_WIDTH-1:0] d;
    logic [DIGITS-1:0]           en, bl;
    for (int c = 0; c < ncyc; c++) begin
      ld = 0; d = DIGITS*SEG_WIDTH'($urandom); en = DIGITS'($urandom); bl = DIGITS'($urandom);
      case (c)
        2:  begin ld = 1; d = {7'h66, 7'h4F, 7'h5B, 7'h06}; en = 4'hF; bl = 4'h0; end
        20: begin ld = 1; d = {7'h66, 7'h4F, 7'h5B, 7'h3F}; en = 4'hF; bl = 4'h0; end
        36: begin ld = 1; d = {7'h66, 7'h4F, 7'h5B, 7'h06}; en = 4'hF; bl = 4'h0; end
        40: begin ld = 1; d = {7'h66, 7'h4F, 7'h5B, 7'h5B}; en = 4'hF; bl = 4'h0; end
        63: begin ld = 1; d = {7'h66, 7'h4F, 7'h5B, 7'h7D}; en = 4'hF; bl = 4'h0; end
        70: begin ld = 1; d = {7'h66, 7'h4F, 7'h5B, 7'h5B}; en = 4'hF; bl = 4'b0001; end
        default: begin
          if (c >= 200 && $urandom_range(0, 7) == 0) begin
            ld = 1;
            if ($urandom_range(0, 3) != 0) en = 4'hF;
          end
        end
      endcase
      drive_cycle(c, ld, d, en, bl);
    end
  endtask

  initial begin
    load = 0; data_in = '0; enable_in = '0; blink_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg_out",    -1, 32'(seg_out),    32'h7F);
    check("reset_digit_sel",  -1, 32'(digit_sel),  32'hF);
    check("reset_pending",    -1, 32'(pending),    32'h0);
    check("reset_frame_done", -1, 32'(frame_done), 32'h0);

    @(negedge clk); reset = 0; #1;
    run_phase(600);
    @(negedge clk); #1;
    mon_en = 0;
    check("scoreboard_drained", -1, 32'(exp_q.size()), 32'h0);

    // Mid-frame reset while a load is still waiting in the shadow.
    reset = 1; #20;
    loads.delete(); exp_q.delete();
    @(negedge clk); reset = 0; #1;
    run_phase(24);
    mon_en = 0;
    check("pre_reset_pending", 23, 32'(pending), 32'h1);
    #1 reset = 1;
    #1;
    check("async_reset_seg_out",   -1, 32'(seg_out),   32'h7F);
    check("async_reset_digit_sel", -1, 32'(digit_sel), 32'hF);
    check("async_reset_pending",   -1, 32'(pending),   32'h0);
    loads.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0; #1;
    run_phase(300);
    @(negedge clk); #1;
    mon_en = 0;
    check("scoreboard_drained_2", -1, 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
